// File: rtl/mips_multicycle_control_pkg.sv
// rtl/mips_multicycle_control_pkg.sv - shared encodings for the multicycle MIPS control FSM
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_control_outputs.sv
// rtl/mips_control_outputs.sv - combinational state/opcode/mem_ready to control-word decoder
module mips_control_outputs
  import mips_multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_ir_write,
  output logic [1:0] o_pc_source,
  output logic [1:0] o_alu_op,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_illegal_op
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_source     = PCSRC_ALU;
    o_alu_op        = ALUOP_ADD;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_B;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_illegal_op    = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is examined.
        o_alu_src_b  = SRCB_IMM_SH;
        o_illegal_op = ~is_legal_op(i_opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_EXECUTE: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        o_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multicycle MIPS datapath
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
                else           w_next_state = S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDIEX;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: if (Opcode == OP_LW) w_next_state = S_MEMRD;
                else                 w_next_state = S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next_state = S_MEMWB;
                else           w_next_state = S_MEMRD;
      S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
                else           w_next_state = S_MEMWR;
      S_EXECUTE: w_next_state = S_RTYPEWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  mips_control_outputs u_outputs (
    .i_state         (r_state),
    .i_opcode        (Opcode),
    .i_mem_ready     (mem_ready),
    .o_pc_write      (w_pc_write),
    .o_pc_write_cond (w_pc_write_cond),
    .o_iord          (IorD),
    .o_mem_read      (w_mem_read),
    .o_mem_write     (w_mem_write),
    .o_mem_to_reg    (MemtoReg),
    .o_ir_write      (w_ir_write),
    .o_pc_source     (PCSource),
    .o_alu_op        (w_alu_op),
    .o_alu_src_a     (ALUSrcA),
    .o_alu_src_b     (ALUSrcB),
    .o_reg_write     (w_reg_write),
    .o_reg_dst       (RegDst),
    .o_illegal_op    (illegal_op)
  );

  // State sits at FETCH during reset, so side-effecting strobes must be gated off.
  assign PCWrite     = w_pc_write & ~reset;
  assign PCWriteCond = w_pc_write_cond & ~reset;
  assign MemRead     = w_mem_read & ~reset;
  assign MemWrite    = w_mem_write & ~reset;
  assign IRWrite     = w_ir_write & ~reset;
  assign RegWrite    = w_reg_write & ~reset;
  assign ALUOp1      = w_alu_op[1];
  assign ALUOp0      = w_alu_op[0];
  assign state       = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - testbench for mips_multicycle_control
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] exp_state;
    ctrl_t      exp_ctrl;
    int         row;
  } vec_t;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUSrcB;
  logic       ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state;
  ctrl_t      w_act;

  int n_checks = 0;
  int n_pass   = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign w_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  PCSource, ALUOp1, ALUOp0, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", what, act, exp);
  endtask

  ctrl_t e_fetch, e_stall, e_rst, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr;
  ctrl_t e_exe, e_rwb, e_br, e_jmp, e_aex, e_awb;
  vec_t  tbl[$];
  vec_t  sb[$];

  function automatic vec_t mk(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                              input ctrl_t c);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctrl = c; v.row = tbl.size();
    return v;
  endfunction

  initial begin
    e_fetch = '0; e_fetch.mem_read = 1; e_fetch.alu_src_b = 2'b01;
    e_fetch.ir_write = 1; e_fetch.pc_write = 1;
    e_stall = '0; e_stall.mem_read = 1; e_stall.alu_src_b = 2'b01;
    e_rst   = '0; e_rst.alu_src_b = 2'b01;
    e_dec   = '0; e_dec.alu_src_b = 2'b11;
    e_ill   = '0; e_ill.alu_src_b = 2'b11; e_ill.illegal_op = 1;
    e_madr  = '0; e_madr.alu_src_a = 1; e_madr.alu_src_b = 2'b10;
    e_mrd   = '0; e_mrd.mem_read = 1; e_mrd.iord = 1;
    e_mwb   = '0; e_mwb.mem_to_reg = 1; e_mwb.reg_write = 1;
    e_mwr   = '0; e_mwr.mem_write = 1; e_mwr.iord = 1;
    e_exe   = '0; e_exe.alu_src_a = 1; e_exe.alu_op = 2'b10;
    e_rwb   = '0; e_rwb.reg_dst = 1; e_rwb.reg_write = 1;
    e_br    = '0; e_br.alu_src_a = 1; e_br.alu_op = 2'b01;
    e_br.pc_write_cond = 1; e_br.pc_source = 2'b01;
    e_jmp   = '0; e_jmp.pc_write = 1; e_jmp.pc_source = 2'b10;
    e_aex   = '0; e_aex.alu_src_a = 1; e_aex.alu_src_b = 2'b10;
    e_awb   = '0; e_awb.reg_write = 1;

    // lw: 5 cycles
    tbl.push_back(mk(LW, 1, 0, e_fetch)); tbl.push_back(mk(LW, 1, 1, e_dec));
    tbl.push_back(mk(LW, 1, 2, e_madr));  tbl.push_back(mk(LW, 1, 3, e_mrd));
    tbl.push_back(mk(LW, 1, 4, e_mwb));
    // R-type: 4 cycles
    tbl.push_back(mk(RT, 1, 0, e_fetch)); tbl.push_back(mk(RT, 1, 1, e_dec));
    tbl.push_back(mk(RT, 1, 6, e_exe));   tbl.push_back(mk(RT, 1, 7, e_rwb));
    // beq, j: 3 cycles each
    tbl.push_back(mk(BEQ, 1, 0, e_fetch)); tbl.push_back(mk(BEQ, 1, 1, e_dec));
    tbl.push_back(mk(BEQ, 1, 8, e_br));
    tbl.push_back(mk(JMP, 1, 0, e_fetch)); tbl.push_back(mk(JMP, 1, 1, e_dec));
    tbl.push_back(mk(JMP, 1, 9, e_jmp));
    // addi: 4 cycles
    tbl.push_back(mk(ADDI, 1, 0, e_fetch)); tbl.push_back(mk(ADDI, 1, 1, e_dec));
    tbl.push_back(mk(ADDI, 1, 10, e_aex));  tbl.push_back(mk(ADDI, 1, 11, e_awb));
    // illegal: 2 cycles
    tbl.push_back(mk(BAD, 1, 0, e_fetch)); tbl.push_back(mk(BAD, 1, 1, e_ill));
    // fetch stall of 3 cycles, then sw with 2 wait cycles
    tbl.push_back(mk(SW, 0, 0, e_stall)); tbl.push_back(mk(SW, 0, 0, e_stall));
    tbl.push_back(mk(SW, 0, 0, e_stall)); tbl.push_back(mk(SW, 1, 0, e_fetch));
    tbl.push_back(mk(SW, 1, 1, e_dec));   tbl.push_back(mk(SW, 1, 2, e_madr));
    tbl.push_back(mk(SW, 0, 5, e_mwr));   tbl.push_back(mk(SW, 0, 5, e_mwr));
    tbl.push_back(mk(SW, 1, 5, e_mwr));
    // lw with one wait cycle in MEMRD, then the next fetch
    tbl.push_back(mk(LW, 1, 0, e_fetch)); tbl.push_back(mk(LW, 1, 1, e_dec));
    tbl.push_back(mk(LW, 1, 2, e_madr));  tbl.push_back(mk(LW, 0, 3, e_mrd));
    tbl.push_back(mk(LW, 1, 3, e_mrd));   tbl.push_back(mk(LW, 1, 4, e_mwb));
    tbl.push_back(mk(LW, 1, 0, e_fetch));

    reset = 1'b1; mem_ready = 1'b1; Opcode = LW;
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(w_act), 32'(e_rst));

    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      Opcode = tbl[i].op;
      mem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      #2;
      begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("row%0d_state", e.row), 32'(state), 32'(e.exp_state));
        check($sformatf("row%0d_ctrl", e.row), 32'(w_act), 32'(e.exp_ctrl));
      end
      @(negedge clk);
    end

    // Reset asserted asynchronously while waiting in MEMRD.
    Opcode = LW; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    check("pre_reset_state", 32'(state), 32'd3);
    check("pre_reset_memread", 32'(MemRead), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_ctrl", 32'(w_act), 32'(e_rst));
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state), 32'd0);
    check("rst_hold_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #2;
    check("post_rst_fetch", 32'(w_act), 32'(e_fetch));
    @(posedge clk);
    #1;
    check("post_rst_decode", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback steps per instruction.
- Drives all datapath enables and mux selects.
- Supplies ALUOp1/ALUOp0 to the existing ALU control decoder:
  - 00 = add
  - 01 = subtract
  - 10 = decode Funct
- Stalls on a memory-ready handshake for instruction fetch and data access.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Opcode  input  6  IR[31:26]; valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
- IRWrite  output  1  instruction register load
- PCSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- ALUOp1  output  1  ALU op class, high bit
- ALUOp0  output  1  ALU op class, low bit
- ALUSrcA  output  1  ALU A operand: 0=PC, 1=A register
- ALUSrcB  output  2  ALU B operand: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2
- RegWrite  output  1  register file write
- RegDst  output  1  destination register: 0=rt, 1=rd
- illegal_op  output  1  high in DECODE when Opcode is unrecognised
- state  output  4  current state, for debug/observation

Behaviour:
- State register: 4-bit, the only sequential element. Outputs decode combinationally from state, Opcode and mem_ready.
- Any output not listed for a state is 0.
- Reset:
  - reset=1 sets state=FETCH asynchronously.
  - While reset is high, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0.
  - After reset deasserts, the first active edge evaluates FETCH.
  - Reset mid-instruction abandons the instruction; no partial writeback is issued.
- FETCH (0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (1):
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Opcode: LW/SW→MEMADR, RTYPE→EXECUTE, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX.
  - Any other Opcode: illegal_op=1 for this cycle, next state FETCH (instruction treated as NOP).
- MEMADR (2):
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Go to MEMRD if Opcode=LW, otherwise MEMWR.
- MEMRD (3):
  - Outputs: MemRead=1, IorD=1.
  - Hold until mem_ready=1, then go to MEMWB.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
- MEMWR (5):
  - Outputs: MemWrite=1, IorD=1, held while waiting.
  - Go to FETCH when mem_ready=1.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RTYPEWB.
- RTYPEWB (7): RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
- JUMP (9): PCWrite=1, PCSource=10; next FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
- ADDIWB (11): RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
- Encodings 12–15: all outputs 0; next FETCH (self-recovery).
- Cycle counts with mem_ready always 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each wait cycle on mem_ready adds exactly one cycle.

Decomposition:
- Shared package holds:
  - opcode constants
  - 4-bit state encodings
  - ALUOp encodings (ADD=2'b00, SUB=2'b01, FUNCT=2'b10)
  - ALUSrcB encodings
  - PCSource encodings
- One natural sub-module: mips_control_outputs, a pure combinational state/Opcode/mem_ready → control-word decoder.
- The top module keeps the state register and next-state logic.

Test Plan:
- Reset:
  - Assert reset mid-MEMRD → state=0 immediately with MemRead=0 during reset.
  - Release reset with mem_ready=1 → next edge state=1.
- lw (Opcode=100011), mem_ready=1:
  - state sequence 0,1,2,3,4,0.
  - In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
- R-type (Opcode=000000):
  - state 6 shows ALUOp1=1, ALUOp0=0.
  - state 7 shows RegDst=1, RegWrite=1.
  - Back to FETCH after 4 cycles.
- beq (Opcode=000100):
  - state 8 shows ALUOp1=0, ALUOp0=1, PCWriteCond=1, PCSource=01.
  - 3 cycles total.
- Memory stall:
  - FETCH with mem_ready=0 for 3 cycles → state holds 0, IRWrite=0, PCWrite=0.
  - mem_ready=1 on 4th cycle → IRWrite=1, PCWrite=1 that cycle; state=1 next.
  - sw with 2 wait cycles → MemWrite=1 for 3 consecutive cycles.
- Illegal opcode 111111:
  - DECODE shows illegal_op=1; next state 0.
  - No RegWrite, MemWrite or PCWrite asserted in DECODE.
